arya_thread_emulator: RTL and testbench

Parametrised per-core thread emulator standing in for a real Arya core during scheduler and top-level bring-up. Each thread channel accepts a start request from the thread scheduler, stays busy for a programmable number of enabled cycles or until a manual debug trigger, then returns a one-cycle done pulse. Channels can be aborted. Run-time gating is provided by `en`. It sits between the multicore thread scheduler and the core slot.

---
 rtl/arya_thread_emulator.sv | 75 +++++++
 tb/tb_arya_thread_emulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arya_thread_emulator.sv
// arya_thread_emulator: per-core thread channels that stand in for a real Arya core.
// Each channel runs busy for a latched number of enabled cycles or until a debug trigger.
module arya_thread_emulator #(
    parameter int NUM_THREADS_PER_CORE = 4,
    parameter int COUNT_WIDTH          = 10
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        en,
    input  logic [NUM_THREADS_PER_CORE-1:0]             start_thread,
    input  logic [NUM_THREADS_PER_CORE*COUNT_WIDTH-1:0] latency_cfg,
    input  logic [NUM_THREADS_PER_CORE-1:0]             abort_thread,
    input  logic                                        debug_on,
    input  logic [NUM_THREADS_PER_CORE-1:0]             debug_commands,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_busy,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_done,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_aborted
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [COUNT_WIDTH-1:0] one = COUNT_WIDTH'(1);
    logic [NUM_THREADS_PER_CORE-1:0] prev;
    logic [NUM_THREADS_PER_CORE-1:0] trig;
    // Edge history runs even while en=0 so a held command never re-triggers.
    always_ff @(posedge clk) begin
        if (!reset) prev <= '0;
        else        prev <= debug_commands;
    end
    assign trig = debug_commands & ~prev;
    for (genvar i = 0; i < NUM_THREADS_PER_CORE; i++) begin : g_thr
        state_t                 state, state_nxt;
        logic [COUNT_WIDTH-1:0] cnt, cnt_nxt, lat;
        logic                   done_q, done_nxt, abort_q, abort_nxt, fin;
        assign lat = latency_cfg[COUNT_WIDTH*i +: COUNT_WIDTH];
        assign fin = debug_on ? trig[i] : (cnt <= one);
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            done_nxt  = 1'b0;
            abort_nxt = 1'b0;
            if (en) begin
                if (state == IDLE) begin
                    if (start_thread[i]) begin
                        state_nxt = BUSY;
                        cnt_nxt   = (lat == '0) ? one : lat;
                    end
                end else begin
                    cnt_nxt = (cnt == '0) ? cnt : cnt - one;
                    if (abort_thread[i]) begin
                        state_nxt = IDLE;
                        abort_nxt = 1'b1;
                    end else if (fin) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
        end
        always_ff @(posedge clk) begin
            if (!reset) begin
                state   <= IDLE;
                cnt     <= '0;
                done_q  <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                done_q  <= done_nxt;
                abort_q <= abort_nxt;
            end
        end
        assign thread_busy[i]    = (state == BUSY);
        assign thread_done[i]    = done_q;
        assign thread_aborted[i] = abort_q;
    end
endmodule

// File: tb/tb_arya_thread_emulator.sv
// tb_arya_thread_emulator: table-driven latency vectors plus hand sequences, with a
// scoreboard queue holding the cycle each done pulse is due on.
module tb_arya_thread_emulator;
    localparam int NT = 4;
    localparam int CW = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b0;
    logic [NT-1:0]      start_thread = '0;
    logic [NT*CW-1:0]   latency_cfg = '0;
    logic [NT-1:0]      abort_thread = '0;
    logic               debug_on = 1'b0;
    logic [NT-1:0]      debug_commands = '0;
    logic [NT-1:0]      thread_busy, thread_done, thread_aborted;

    arya_thread_emulator #(.NUM_THREADS_PER_CORE(NT), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .start_thread(start_thread),
        .latency_cfg(latency_cfg), .abort_thread(abort_thread), .debug_on(debug_on),
        .debug_commands(debug_commands), .thread_busy(thread_busy),
        .thread_done(thread_done), .thread_aborted(thread_aborted)
    );

    always #5 clk = ~clk;

    typedef struct { int thr; int lat; int exp_busy; } vec_t;
    typedef struct { int thr; int due; } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        for (int i = 0; i < NT; i++) begin
            if (thread_done[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected thread %0d cycle %0d got done=1 want 0", i, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.thr != i || e.due != cyc) begin
                        errors++;
                        $display("FAIL done_match got thread %0d cycle %0d want thread %0d cycle %0d",
                                 i, cyc, e.thr, e.due);
                    end
                end
            end
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing thread %0d got no done want cycle %0d", sb[0].thr, sb[0].due);
            void'(sb.pop_front());
        end
    endtask

    // Outputs are sampled on the falling edge, after the rising edge they follow.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sb_check();
    endtask

    task automatic run_vec(input vec_t v);
        int nb, other;
        latency_cfg[v.thr*CW +: CW] = CW'(v.lat);
        start_thread = '0;
        start_thread[v.thr] = 1'b1;
        sb.push_back('{thr: v.thr, due: cyc + 1 + v.exp_busy});
        step();
        start_thread = '0;
        nb = 0;
        other = 0;
        for (int k = 0; k < v.exp_busy + 4; k++) begin
            if (thread_busy[v.thr]) nb++;
            if ((thread_busy & ~(NT'(1) << v.thr)) != '0) other++;
            step();
        end
        check($sformatf("busy_len_t%0d_l%0d", v.thr, v.lat), nb, v.exp_busy);
        check("other_busy", other, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    vec_t vecs[6];
    int   nb;

    initial begin
        vecs[0] = '{thr: 0, lat: 5,    exp_busy: 5};
        vecs[1] = '{thr: 1, lat: 0,    exp_busy: 1};
        vecs[2] = '{thr: 2, lat: 1023, exp_busy: 1023};
        vecs[3] = '{thr: 3, lat: 3,    exp_busy: 3};
        vecs[4] = '{thr: 1, lat: 1,    exp_busy: 1};
        vecs[5] = '{thr: 2, lat: 2,    exp_busy: 2};

        step();
        step();
        check("rst_busy", int'(thread_busy), 0);
        check("rst_done", int'(thread_done), 0);
        check("rst_aborted", int'(thread_aborted), 0);
        reset = 1'b1;
        en = 1'b1;
        step();

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Debug completion: counter expiry ignored, one done per rising edge of the command.
        debug_on = 1'b1;
        latency_cfg[3*CW +: CW] = CW'(2);
        start_thread[3] = 1'b1;
        step();
        start_thread = '0;
        nb = 0;
        repeat (20) begin
            if (thread_busy[3]) nb++;
            step();
        end
        check("dbg_hold_busy", nb, 20);
        debug_commands[3] = 1'b1;
        sb.push_back('{thr: 3, due: cyc + 1});
        step();
        check("dbg_busy_clr", int'(thread_busy[3]), 0);
        repeat (9) step();
        debug_commands = '0;
        step();
        check("dbg_sb", sb.size(), 0);
        debug_commands[0] = 1'b1;
        step();
        debug_commands = '0;
        step();
        check("dbg_idle_trig", int'(thread_busy), 0);
        // Leaving debug mode with the counter already expired finishes on the next edge.
        start_thread[3] = 1'b1;
        step();
        start_thread = '0;
        repeat (4) step();
        check("dbg_still_busy", int'(thread_busy[3]), 1);
        debug_on = 1'b0;
        sb.push_back('{thr: 3, due: cyc + 1});
        step();
        check("dbg_off_done", int'(thread_busy[3]), 0);
        step();

        // en stall of 4 cycles delays done by 4; start while busy is ignored.
        latency_cfg[0 +: CW] = CW'(8);
        start_thread[0] = 1'b1;
        sb.push_back('{thr: 0, due: cyc + 1 + 8 + 4});
        step();
        start_thread = '0;
        repeat (2) step();
        en = 1'b0;
        start_thread[0] = 1'b1;
        repeat (4) step();
        check("stall_busy_hold", int'(thread_busy[0]), 1);
        en = 1'b1;
        step();
        start_thread = '0;
        repeat (15) step();
        check("stall_sb", sb.size(), 0);
        check("stall_idle", int'(thread_busy[0]), 0);

        // Abort on the same edge the counter would complete.
        latency_cfg[1*CW +: CW] = CW'(3);
        start_thread[1] = 1'b1;
        step();
        start_thread = '0;
        repeat (2) step();
        abort_thread[1] = 1'b1;
        step();
        abort_thread = '0;
        check("abort_pulse", int'(thread_aborted), 2);
        check("abort_busy", int'(thread_busy[1]), 0);
        step();
        check("abort_one_cycle", int'(thread_aborted), 0);
        abort_thread[1] = 1'b1;
        step();
        abort_thread = '0;
        check("abort_idle", int'(thread_aborted), 0);
        repeat (4) step();

        // Two channels completing at different times from one shared start edge.
        latency_cfg[0 +: CW] = CW'(2);
        latency_cfg[1*CW +: CW] = CW'(4);
        start_thread = 4'b0011;
        sb.push_back('{thr: 0, due: cyc + 3});
        sb.push_back('{thr: 1, due: cyc + 5});
        step();
        start_thread = '0;
        check("dual_busy", int'(thread_busy), 3);
        repeat (6) step();
        check("dual_sb", sb.size(), 0);

        // Reset mid-operation clears everything without pulses.
        latency_cfg[0 +: CW] = CW'(10);
        latency_cfg[2*CW +: CW] = CW'(10);
        start_thread = 4'b0101;
        step();
        start_thread = '0;
        step();
        check("pre_rst_busy", int'(thread_busy), 5);
        reset = 1'b0;
        step();
        check("mid_rst_busy", int'(thread_busy), 0);
        check("mid_rst_done", int'(thread_done), 0);
        check("mid_rst_aborted", int'(thread_aborted), 0);
        reset = 1'b1;
        repeat (12) step();
        run_vec('{thr: 0, lat: 5, exp_busy: 5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
